fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_perf_counter.sv | 21 ++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: halt opcode,
// FSM state encoding and performance-counter width/saturation value.
package fetch_pkg;

  localparam logic [15:0] HALT_OPCODE = 16'hEFFF;

  localparam int CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Single saturating event counter used for the fetch-stage
// performance statistics. Sticks at CNT_MAX instead of wrapping.
module fetch_perf_counter
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Count one event per cycle, holding once the maximum is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// and fills the IF/ID register. Handles stall, branch redirect (bubble),
// halt opcode and out-of-range fetch fault.
// Optional performance counters are built when FETCH_PERF_CNT_EN is
// defined; otherwise the perf_* ports are tied to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] PC_STEP  = 16'd2,
  parameter logic [15:0] MEM_LAST = 16'd56,
  parameter logic [15:0] RESET_PC = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] instruction,
  output logic [15:0] pcOut,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic        fetch_fault,
  output logic [15:0] perf_fetch,
  output logic [15:0] perf_stall,
  output logic [15:0] perf_flush
);

  fetch_state_t state, state_next;

  logic [15:0] pc_next;
  logic [15:0] instr_next;
  logic [15:0] ifpc_next;
  logic        valid_next;
  logic        halted_next;
  logic        fault_next;

  // State register; memory and IF/ID contents update together with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pcOut       <= RESET_PC;
      if_instr    <= '0;
      if_pc       <= '0;
      if_valid    <= 1'b0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      pcOut       <= pc_next;
      if_instr    <= instr_next;
      if_pc       <= ifpc_next;
      if_valid    <= valid_next;
      halted      <= halted_next;
      fetch_fault <= fault_next;
    end
  end

  // Next-state and datapath selection: redirect beats stall beats fetch
  always_comb begin
    state_next  = state;
    pc_next     = pcOut;
    instr_next  = if_instr;
    ifpc_next   = if_pc;
    valid_next  = if_valid;
    halted_next = halted;
    fault_next  = fetch_fault;

    case (state)
      IDLE: begin
        valid_next = 1'b0;
        state_next = RUN;
      end

      RUN: begin
        if (branch_taken) begin
          pc_next    = {branch_target[15:1], 1'b0};
          instr_next = '0;
          valid_next = 1'b0;
        end else if (stall) begin
          pc_next = pcOut;
        end else if (pcOut > MEM_LAST) begin
          valid_next  = 1'b0;
          fault_next  = 1'b1;
          halted_next = 1'b1;
          state_next  = HALT;
        end else begin
          instr_next = instruction;
          ifpc_next  = pcOut;
          valid_next = 1'b1;
          if (instruction == HALT_OPCODE) begin
            halted_next = 1'b1;
            state_next  = HALT;
          end else begin
            pc_next = pcOut + PC_STEP;
          end
        end
      end

      HALT: begin
        valid_next = 1'b0;
        if (branch_taken) begin
          pc_next     = {branch_target[15:1], 1'b0};
          instr_next  = '0;
          halted_next = 1'b0;
          state_next  = RUN;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc;
  logic stall_inc;
  logic flush_inc;

  assign fetch_inc = (state == RUN) && !branch_taken && !stall && (pcOut <= MEM_LAST);
  assign stall_inc = (state == RUN) && stall && !branch_taken;
  assign flush_inc = ((state == RUN) || (state == HALT)) && branch_taken;

  fetch_perf_counter u_cnt_fetch (
    .clk   (clk),
    .rst   (rst),
    .inc   (fetch_inc),
    .count (perf_fetch)
  );

  fetch_perf_counter u_cnt_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (perf_stall)
  );

  fetch_perf_counter u_cnt_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (perf_flush)
  );
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit. Expected IF/ID and status
// values are queued before each clock and popped after it.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instruction;
  logic [15:0] pcOut;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic        fetch_fault;
  logic [15:0] perf_fetch;
  logic [15:0] perf_stall;
  logic [15:0] perf_flush;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic        valid;
    logic        hlt;
    logic        fault;
    bit          chk_instr;
    bit          chk_ipc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruction   (instruction),
    .pcOut         (pcOut),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .halted        (halted),
    .fetch_fault   (fetch_fault),
    .perf_fetch    (perf_fetch),
    .perf_stall    (perf_stall),
    .perf_flush    (perf_flush)
  );

  always #5 clk = ~clk;

  // Instruction memory model, combinational read
  function automatic logic [15:0] memWord(input logic [15:0] a);
    case (a)
      16'd0:   memWord = 16'hF120;
      16'd2:   memWord = 16'hF121;
      16'd4:   memWord = 16'hF343;
      16'd8:   memWord = 16'hF564;
      16'd50:  memWord = 16'hEFFF;
      default: memWord = {8'h10, a[7:0]};
    endcase
  endfunction

  assign instruction = memWord(pcOut);

  task automatic cmp16(input string tag, input string field,
                       input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [15:0] pc,
                         input logic [15:0] instr, input logic [15:0] ipc,
                         input logic valid, input logic hlt, input logic fault,
                         input bit ci, input bit cp);
    exp_t e;
    e.tag = tag; e.pc = pc; e.instr = instr; e.ipc = ipc;
    e.valid = valid; e.hlt = hlt; e.fault = fault;
    e.chk_instr = ci; e.chk_ipc = cp;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic st, input logic br, input logic [15:0] tgt);
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      cmp16(e.tag, "pcOut", pcOut, e.pc);
      cmp16(e.tag, "if_valid", {15'd0, if_valid}, {15'd0, e.valid});
      cmp16(e.tag, "halted", {15'd0, halted}, {15'd0, e.hlt});
      cmp16(e.tag, "fetch_fault", {15'd0, fetch_fault}, {15'd0, e.fault});
      if (e.chk_instr) cmp16(e.tag, "if_instr", if_instr, e.instr);
      if (e.chk_ipc)   cmp16(e.tag, "if_pc", if_pc, e.ipc);
    end
  endtask

  task automatic checkPerf(input string tag, input logic [15:0] f,
                           input logic [15:0] s, input logic [15:0] fl);
`ifdef FETCH_PERF_CNT_EN
    cmp16(tag, "perf_fetch", perf_fetch, f);
    cmp16(tag, "perf_stall", perf_stall, s);
    cmp16(tag, "perf_flush", perf_flush, fl);
`else
    cmp16(tag, "perf_fetch", perf_fetch, 16'd0);
    cmp16(tag, "perf_stall", perf_stall, 16'd0);
    cmp16(tag, "perf_flush", perf_flush, 16'd0);
`endif
  endtask

  // One clocked step: queue expectation, drive, clock, compare
  task automatic step(input string tag, input logic st, input logic br,
                      input logic [15:0] tgt, input logic [15:0] pc,
                      input logic [15:0] instr, input logic [15:0] ipc,
                      input logic valid, input logic hlt, input logic fault,
                      input bit ci, input bit cp);
    pushExp(tag, pc, instr, ipc, valid, hlt, fault, ci, cp);
    applyStimulus(st, br, tgt);
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #12;
    pushExp("reset", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput();
    checkPerf("reset", 16'd0, 16'd0, 16'd0);
    rst = 1'b0;

    // IDLE cycle, then free run
    step("idle",   0, 0, 16'd0, 16'd0, 16'h0000, 16'd0, 0, 0, 0, 1, 1);
    step("f0",     0, 0, 16'd0, 16'd2, 16'hF120, 16'd0, 1, 0, 0, 1, 1);
    step("f2",     0, 0, 16'd0, 16'd4, 16'hF121, 16'd2, 1, 0, 0, 1, 1);
    step("f4",     0, 0, 16'd0, 16'd6, 16'hF343, 16'd4, 1, 0, 0, 1, 1);
    step("f6",     0, 0, 16'd0, 16'd8, 16'h1006, 16'd6, 1, 0, 0, 1, 1);

    // Stall three cycles at PC 8
    step("stall1", 1, 0, 16'd0, 16'd8, 16'h1006, 16'd6, 1, 0, 0, 1, 1);
    step("stall2", 1, 0, 16'd0, 16'd8, 16'h1006, 16'd6, 1, 0, 0, 1, 1);
    step("stall3", 1, 0, 16'd0, 16'd8, 16'h1006, 16'd6, 1, 0, 0, 1, 1);
    step("rel",    0, 0, 16'd0, 16'd10, 16'hF564, 16'd8, 1, 0, 0, 1, 1);
    checkPerf("afterstall", 16'd5, 16'd3, 16'd0);

    // Branch with simultaneous stall, odd target rounds down
    step("brst",   1, 1, 16'h001B, 16'h001A, 16'h0000, 16'd0, 0, 0, 0, 1, 0);
    step("f1a",    0, 0, 16'd0, 16'h001C, 16'h101A, 16'h001A, 1, 0, 0, 1, 1);

    // Halt opcode at 50, then redirect out of HALT to 24
    step("br50",   0, 1, 16'd50, 16'd50, 16'h0000, 16'd0, 0, 0, 0, 1, 0);
    step("halt",   0, 0, 16'd0, 16'd50, 16'hEFFF, 16'd50, 1, 1, 0, 1, 1);
    step("halt2",  0, 0, 16'd0, 16'd50, 16'hEFFF, 16'd50, 0, 1, 0, 1, 1);
    step("br24",   0, 1, 16'd24, 16'd24, 16'h0000, 16'd0, 0, 0, 0, 0, 0);
    step("f24",    0, 0, 16'd0, 16'd26, 16'h1018, 16'd24, 1, 0, 0, 1, 1);

    // Branch past the end of memory: accepted, fault on next fetch
    step("br58",   0, 1, 16'd58, 16'd58, 16'h0000, 16'd0, 0, 0, 0, 1, 0);
    step("fault",  0, 0, 16'd0, 16'd58, 16'h0000, 16'd0, 0, 1, 1, 1, 0);
    step("fault2", 0, 0, 16'd0, 16'd58, 16'h0000, 16'd0, 0, 1, 1, 1, 0);
    step("br20",   0, 1, 16'd20, 16'd20, 16'h0000, 16'd0, 0, 0, 1, 1, 0);
    checkPerf("beforerst", 16'd8, 16'd3, 16'd5);

    // Asynchronous reset between edges while running at PC 20
    #2;
    rst = 1'b1;
    #1;
    pushExp("asyncrst", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput();
    checkPerf("asyncrst", 16'd0, 16'd0, 16'd0);
    #3;
    rst = 1'b0;

    step("idle2",  0, 0, 16'd0, 16'd0, 16'h0000, 16'd0, 0, 0, 0, 1, 1);
    step("f0b",    0, 0, 16'd0, 16'd2, 16'hF120, 16'd0, 1, 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
